cmp_slicer: RTL and testbench
=============================

# cmp_slicer

Upstream feeder for the compare ALU. It loads one 64-row × 24-column bitmap from glyph memory into a local buffer, then drives the ALU's start, column, top-row and bottom-row slice handshakes. When the ALU finishes, it captures the 13-bit shift/scale result. It sits between the bitmap memory read port and the compare ALU inside the compare accelerator.

## Interface
- No parameters. Geometry is fixed: 64 rows, 24 columns, 24-bit memory words (one row per word).
- Reset is synchronous, active-low (`rst_n`); there is one clock (`clk`).
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- go  in  1  start request; sampled in IDLE only
- busy  out  1  high in every state except IDLE
- mem_rd  out  1  memory read strobe
- mem_addr  out  6  row address
- mem_rdata  in  24  row data, valid on the cycle after mem_rd; bit 23 = leftmost pixel
- alu_start  out  1  one-cycle ALU reset/start pulse
- bitcolumn  out  64  current column; bit i = row i
- bitrowtop  out  24  current top-scan row
- bitrowbot  out  24  current bottom-scan row
- nextcolumnready / nextrowtopready / nextrowbotready  out  1  one-cycle load strobes to the ALU
- nextcolumn / nextrowtop / nextrowbot  in  1  ALU "slice checked" levels
- lastcolumn  out  1  final-column flag to the ALU
- alu_result  in  13  ALU result
- alu_done  in  1  ALU finished level
- result  out  13  captured result
- done  out  1  one-cycle completion pulse

## Operation
- **IDLE:** on go=1, go to LOAD. The row counter resets to 0.
- **LOAD:** mem_rd=1 with mem_addr=0..63 on consecutive cycles. Each mem_rdata is written to buf[addr of previous cycle]. After the 64th word is written, go to START.
- **START:** alu_start=1 for exactly one cycle. Slice counters reset: col=0, top=0, bot=63. Then go to FEED.
- **FEED:** three independent channels.
  - Column channel: slices 0..23. Column c uses mem bit (23−c) of every row.
  - Top channel: rows 0..31, ascending.
  - Bottom channel: rows 63..32, descending.
- **Per-channel rules:**
  - Issue slice 0 in the first FEED cycle, unconditionally.
  - Each issue drives the slice data bus and pulses the ready strobe for one cycle, and sets `pending`.
  - `pending` clears on the first cycle the matching next* input is observed 0.
  - The next slice may be issued when pending=0 and next*=1.
  - Data buses hold their value between issues.
  - A channel is exhausted after its last slice has been issued and then acknowledged (pending cleared, next*=1). An exhausted channel issues nothing further.
- **lastcolumn:** asserts the cycle the column channel becomes exhausted. It holds until leaving WAIT_DONE.
- **Exit from FEED:** when all three channels are exhausted, go to WAIT_DONE.
- **WAIT_DONE:** when alu_done=1, latch result ← alu_result and go to DONE.
- **DONE:** done=1 for one cycle, then go to IDLE. result holds until the next capture or reset.
- **go handling:** go outside IDLE is ignored.

## Timing
- **Reset values:** every output is 0, including result, busy, mem_addr and the slice buses. rst_n low in any state returns the block to IDLE on the next edge, with no ALU strobes.
- **LOAD:** exactly 65 cycles (64 reads plus the final write).
- **START:** alu_start is high the cycle after the final buffer write.
- **First issue:** first ready strobes fire in the cycle after alu_start, never in the same cycle.
- **Minimum issue spacing:** 3 cycles per channel, because the ALU clears its checked flag one cycle after the strobe and sets it one cycle later.
- **Simultaneous events:** strobes from different channels in the same cycle are independent and allowed.
- **Exhaustion:**
  - Top and bottom channels never issue beyond 32 rows each, so the ALU's 6-bit counters cannot wrap.
  - Once a channel is exhausted, its next* inputs are ignored.
- **Capture:** if alu_done is already high on WAIT_DONE entry, capture happens on that first cycle.

## Test plan
- **All-zero bitmap:**
  - 65 LOAD cycles, then alu_start.
  - 24 column strobes, and 32 top and 32 bottom strobes.
  - lastcolumn high after the 24th acknowledgement.
  - result = alu_result captured, with a single done pulse.
- **Row 5 = 24'h800000, rest zero:**
  - bitcolumn for column 0 = 64'h20; every other column = 0.
  - bitrowtop for the 6th top issue = 24'h800000.
- **ALU model with variable acknowledgement delay (2–7 cycles per channel):**
  - No strobe is issued while its channel is pending.
  - Minimum strobe spacing is 3 cycles.
  - Strobe counts are exactly 24/32/32.
- **go pulsed during FEED:** no effect; busy stays 1 and the sequence completes normally.
- **rst_n low during LOAD and again during FEED:**
  - Next cycle all outputs are 0 and the state is IDLE.
  - A following go performs a full clean run.
- **alu_done already high when FEED ends:**
  - result is captured on the first WAIT_DONE cycle.
  - done is high exactly one cycle later.

Source files
------------

// File: rtl/cmp_slicer.sv
// cmp_slicer: loads one 64x24 glyph bitmap into a local row buffer, then feeds
// the compare ALU with column, top-row and bottom-row slices over three
// independent strobe/acknowledge channels and captures the 13-bit result.
module cmp_slicer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go,
   output logic        busy,
   output logic        mem_rd,
   output logic [5:0]  mem_addr,
   input  logic [23:0] mem_rdata,
   output logic        alu_start,
   output logic [63:0] bitcolumn,
   output logic [23:0] bitrowtop,
   output logic [23:0] bitrowbot,
   output logic        nextcolumnready,
   output logic        nextrowtopready,
   output logic        nextrowbotready,
   input  logic        nextcolumn,
   input  logic        nextrowtop,
   input  logic        nextrowbot,
   output logic        lastcolumn,
   input  logic [12:0] alu_result,
   input  logic        alu_done,
   output logic [12:0] result,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_FEED  = 3'd3,
      S_WAIT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [6:0]  load_cnt_r;
   logic [5:0]  wr_addr_s;
   logic [23:0] rows_r [64];
   logic [4:0]  col_idx_r;
   logic [5:0]  top_idx_r;
   logic [5:0]  bot_idx_r;
   logic        col_pend_r, top_pend_r, bot_pend_r;
   logic        col_exh_r, top_exh_r, bot_exh_r;
   logic        col_ack_s, top_ack_s, bot_ack_s;
   logic        col_issue_s, top_issue_s, bot_issue_s;
   logic        col_fin_s, top_fin_s, bot_fin_s;
   logic [4:0]  col_bit_s;
   logic [63:0] col_data_s;

   logic        busy_r, mem_rd_r, alu_start_r, lastcolumn_r, done_r;
   logic [5:0]  mem_addr_r;
   logic [63:0] bitcolumn_r;
   logic [23:0] bitrowtop_r, bitrowbot_r;
   logic        col_rdy_r, top_rdy_r, bot_rdy_r;
   logic [12:0] result_r;

   assign busy            = busy_r;
   assign mem_rd          = mem_rd_r;
   assign mem_addr        = mem_addr_r;
   assign alu_start       = alu_start_r;
   assign bitcolumn       = bitcolumn_r;
   assign bitrowtop       = bitrowtop_r;
   assign bitrowbot       = bitrowbot_r;
   assign nextcolumnready = col_rdy_r;
   assign nextrowtopready = top_rdy_r;
   assign nextrowbotready = bot_rdy_r;
   assign lastcolumn      = lastcolumn_r;
   assign result          = result_r;
   assign done            = done_r;

   // Read data arrives one cycle late, so it belongs to the previous address
   assign wr_addr_s = load_cnt_r[5:0] - 6'd1;

   // Next-state selection
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE:  if (go) state_s = S_LOAD; else state_s = S_IDLE;
         S_LOAD:  if (load_cnt_r == 7'd64) state_s = S_START; else state_s = S_LOAD;
         S_START: state_s = S_FEED;
         S_FEED:  if (col_exh_r && top_exh_r && bot_exh_r) state_s = S_WAIT; else state_s = S_FEED;
         S_WAIT:  if (alu_done) state_s = S_DONE; else state_s = S_WAIT;
         S_DONE:  state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // Per-channel decisions: slice 0 goes out from START, later slices on acknowledge
   always_comb begin
      col_ack_s   = (state_r == S_FEED) && !col_exh_r && !col_pend_r && nextcolumn;
      top_ack_s   = (state_r == S_FEED) && !top_exh_r && !top_pend_r && nextrowtop;
      bot_ack_s   = (state_r == S_FEED) && !bot_exh_r && !bot_pend_r && nextrowbot;
      col_issue_s = (state_r == S_START) || (col_ack_s && (col_idx_r != 5'd24));
      top_issue_s = (state_r == S_START) || (top_ack_s && (top_idx_r != 6'd32));
      bot_issue_s = (state_r == S_START) || (bot_ack_s && (bot_idx_r != 6'd31));
      col_fin_s   = col_ack_s && (col_idx_r == 5'd24);
      top_fin_s   = top_ack_s && (top_idx_r == 6'd32);
      bot_fin_s   = bot_ack_s && (bot_idx_r == 6'd31);
   end

   // Gather the current column: one pixel from every row, bit 23 is column 0
   always_comb begin
      col_bit_s = 5'd23 - col_idx_r;
      for (int i = 0; i < 64; i++) begin
         col_data_s[i] = rows_r[i][col_bit_s];
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Row buffer fill while loading
   always_ff @(posedge clk) begin
      if ((state_r == S_LOAD) && (load_cnt_r != 7'd0)) begin
         rows_r[wr_addr_s] <= mem_rdata;
      end
   end

   // Memory read sequencing: addresses 0..63 on consecutive cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         load_cnt_r <= 7'd0;
         mem_rd_r   <= 1'b0;
         mem_addr_r <= 6'd0;
      end else if ((state_r == S_IDLE) && go) begin
         load_cnt_r <= 7'd0;
         mem_rd_r   <= 1'b1;
         mem_addr_r <= 6'd0;
      end else if (state_r == S_LOAD) begin
         load_cnt_r <= load_cnt_r + 7'd1;
         if (load_cnt_r < 7'd63) begin
            mem_rd_r   <= 1'b1;
            mem_addr_r <= load_cnt_r[5:0] + 6'd1;
         end else begin
            mem_rd_r   <= 1'b0;
            mem_addr_r <= 6'd0;
         end
      end else begin
         mem_rd_r <= 1'b0;
      end
   end

   // Slice channels: counters, pending/exhausted flags, data buses and strobes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_idx_r   <= 5'd0;
         top_idx_r   <= 6'd0;
         bot_idx_r   <= 6'd0;
         col_pend_r  <= 1'b0;
         top_pend_r  <= 1'b0;
         bot_pend_r  <= 1'b0;
         col_exh_r   <= 1'b0;
         top_exh_r   <= 1'b0;
         bot_exh_r   <= 1'b0;
         col_rdy_r   <= 1'b0;
         top_rdy_r   <= 1'b0;
         bot_rdy_r   <= 1'b0;
         bitcolumn_r <= 64'd0;
         bitrowtop_r <= 24'd0;
         bitrowbot_r <= 24'd0;
      end else begin
         col_rdy_r <= col_issue_s;
         top_rdy_r <= top_issue_s;
         bot_rdy_r <= bot_issue_s;
         if (state_r == S_LOAD) begin
            // counters sit at their first slice so START can issue it directly
            col_idx_r  <= 5'd0;
            top_idx_r  <= 6'd0;
            bot_idx_r  <= 6'd63;
            col_pend_r <= 1'b0;
            top_pend_r <= 1'b0;
            bot_pend_r <= 1'b0;
            col_exh_r  <= 1'b0;
            top_exh_r  <= 1'b0;
            bot_exh_r  <= 1'b0;
         end else begin
            if (col_issue_s) begin
               bitcolumn_r <= col_data_s;
               col_idx_r   <= col_idx_r + 5'd1;
               col_pend_r  <= 1'b1;
            end else if ((state_r == S_FEED) && col_pend_r && !nextcolumn) begin
               col_pend_r <= 1'b0;
            end
            if (top_issue_s) begin
               bitrowtop_r <= rows_r[top_idx_r];
               top_idx_r   <= top_idx_r + 6'd1;
               top_pend_r  <= 1'b1;
            end else if ((state_r == S_FEED) && top_pend_r && !nextrowtop) begin
               top_pend_r <= 1'b0;
            end
            if (bot_issue_s) begin
               bitrowbot_r <= rows_r[bot_idx_r];
               bot_idx_r   <= bot_idx_r - 6'd1;
               bot_pend_r  <= 1'b1;
            end else if ((state_r == S_FEED) && bot_pend_r && !nextrowbot) begin
               bot_pend_r <= 1'b0;
            end
            if (col_fin_s) col_exh_r <= 1'b1;
            if (top_fin_s) top_exh_r <= 1'b1;
            if (bot_fin_s) bot_exh_r <= 1'b1;
         end
      end
   end

   // Status, ALU start, last-column flag and result capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_r       <= 1'b0;
         alu_start_r  <= 1'b0;
         lastcolumn_r <= 1'b0;
         result_r     <= 13'd0;
         done_r       <= 1'b0;
      end else begin
         busy_r      <= (state_s != S_IDLE);
         alu_start_r <= (state_s == S_START);
         done_r      <= (state_s == S_DONE);
         if (col_fin_s) begin
            lastcolumn_r <= 1'b1;
         end else if ((state_r == S_WAIT) && alu_done) begin
            lastcolumn_r <= 1'b0;
         end
         if ((state_r == S_WAIT) && alu_done) begin
            result_r <= alu_result;
         end
      end
   end

endmodule

// File: tb/tb_cmp_slicer.sv
// Bench for cmp_slicer: glyph memory and ALU behavioural models, a cycle-timed
// expectation of every output, and literal pins on selected slices.
module tb_cmp_slicer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        go = 1'b0;
   logic        busy, mem_rd, alu_start, lastcolumn, done;
   logic [5:0]  mem_addr;
   logic [23:0] mem_rdata = 24'd0;
   logic [63:0] bitcolumn;
   logic [23:0] bitrowtop, bitrowbot;
   logic        nextcolumnready, nextrowtopready, nextrowbotready;
   logic        nextcolumn = 1'b1, nextrowtop = 1'b1, nextrowbot = 1'b1;
   logic [12:0] alu_result = 13'd0;
   logic        alu_done = 1'b0;
   logic [12:0] result;

   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          dly_lo = 2;
   int          dly_hi = 2;
   logic [23:0] mem [64];
   logic [63:0] cap_col0, cap_col1;
   logic [23:0] cap_top5;

   always #5 clk = ~clk;

   cmp_slicer dut (
      .clk(clk), .rst_n(rst_n), .go(go), .busy(busy),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .alu_start(alu_start), .bitcolumn(bitcolumn), .bitrowtop(bitrowtop), .bitrowbot(bitrowbot),
      .nextcolumnready(nextcolumnready), .nextrowtopready(nextrowtopready), .nextrowbotready(nextrowbotready),
      .nextcolumn(nextcolumn), .nextrowtop(nextrowtop), .nextrowbot(nextrowbot),
      .lastcolumn(lastcolumn), .alu_result(alu_result), .alu_done(alu_done),
      .result(result), .done(done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Expected slice k of channel ch straight from the bitmap picture
   function automatic logic [63:0] exp_slice(input int ch, input int k);
      logic [63:0] v;
      v = 64'd0;
      case (ch)
         0: for (int i = 0; i < 64; i++) v[i] = mem[i][23 - k];
         1: v = {40'd0, mem[k]};
         default: v = {40'd0, mem[63 - k]};
      endcase
      return v;
   endfunction

   task automatic chk_all_zero(input string nm);
      chk({nm, "_ctrl"}, {busy, mem_rd, mem_addr, alu_start, nextcolumnready, nextrowtopready,
                         nextrowbotready, lastcolumn, result, done}, 64'd0);
      chk({nm, "_col"}, bitcolumn, 64'd0);
      chk({nm, "_rows"}, {16'd0, bitrowtop, bitrowbot}, 64'd0);
   endtask

   // One start-to-done run; alu_mode 1 holds alu_done high from the start.
   // go_rel re-pulses go at that relative cycle; rst_rel drops rst_n at that cycle.
   task automatic run_case(input int alu_mode, input int go_rel, input int rst_rel, input logic [12:0] res_val);
      int g, rel, x, ad_cyc, done_exp;
      int cnt[3], since[3], dly[3], last[3], ack[3], lim[3];
      logic stb[3];
      logic [63:0] busv[3];
      logic [2:0] nx;
      logic prev_rd;
      logic [5:0] prev_addr;
      bit fin;
      lim[0] = 24; lim[1] = 32; lim[2] = 32;
      for (int ch = 0; ch < 3; ch++) begin
         cnt[ch] = 0; since[ch] = -1; dly[ch] = 2; last[ch] = -1; ack[ch] = -1;
      end
      nx = 3'b111;
      nextcolumn = 1'b1; nextrowtop = 1'b1; nextrowbot = 1'b1;
      alu_result = res_val;
      alu_done = (alu_mode == 1);
      prev_rd = 1'b0; prev_addr = 6'd0;
      g = cyc; x = -1; done_exp = -1; fin = 0;
      ad_cyc = (alu_mode == 1) ? g : -1;
      go = 1'b1;
      for (int k = 0; k < 4000 && !fin; k++) begin
         tick();
         rel = cyc - g;
         go = (rel == go_rel);
         mem_rdata = prev_rd ? mem[prev_addr] : 24'h5A5A5A;
         prev_rd = mem_rd; prev_addr = mem_addr;
         if (rst_rel > 0 && rel == rst_rel + 1) begin
            chk_all_zero("after_rst");
            rst_n = 1'b1; go = 1'b0; alu_done = 1'b0;
            nextcolumn = 1'b1; nextrowtop = 1'b1; nextrowbot = 1'b1;
            tick();
            chk("idle_after_rst", {busy, mem_rd, alu_start}, 64'd0);
            return;
         end
         chk("busy", busy, 1'b1);
         chk("mem_rd", mem_rd, rel <= 64);
         if (rel <= 64) chk("mem_addr", mem_addr, rel - 1);
         chk("alu_start", alu_start, rel == 66);
         stb = '{nextcolumnready, nextrowtopready, nextrowbotready};
         busv = '{bitcolumn, {40'd0, bitrowtop}, {40'd0, bitrowbot}};
         for (int ch = 0; ch < 3; ch++) begin
            if (rel <= 67) chk("first_strobe", stb[ch], rel == 67);
            if (stb[ch]) begin
               chk("strobe_while_pending", since[ch] >= 0, 1'b0);
               if (last[ch] >= 0) chk("strobe_spacing", (cyc - last[ch]) >= 3, 1'b1);
               chk("strobe_count", cnt[ch] < lim[ch], 1'b1);
               if (cnt[ch] < lim[ch]) chk("slice_data", busv[ch], exp_slice(ch, cnt[ch]));
               if (ch == 0 && cnt[ch] == 0) cap_col0 = bitcolumn;
               if (ch == 0 && cnt[ch] == 1) cap_col1 = bitcolumn;
               if (ch == 1 && cnt[ch] == 5) cap_top5 = bitrowtop;
               cnt[ch]++;
               last[ch] = cyc;
               since[ch] = 0;
               dly[ch] = int'($urandom_range(dly_hi, dly_lo));
            end else if (since[ch] >= 0) begin
               since[ch]++;
               if (since[ch] >= dly[ch]) begin
                  nx[ch] = 1'b1;
                  since[ch] = -1;
                  if (cnt[ch] == lim[ch]) ack[ch] = cyc;
               end else begin
                  nx[ch] = 1'b0;
               end
            end
         end
         if (x < 0 && ack[0] >= 0 && ack[1] >= 0 && ack[2] >= 0) begin
            x = ack[0];
            if (ack[1] > x) x = ack[1];
            if (ack[2] > x) x = ack[2];
         end
         if (x >= 0 && ad_cyc < 0 && cyc == x + 5) begin
            alu_done = 1'b1;
            ad_cyc = cyc;
         end
         if (x >= 0 && ad_cyc >= 0) done_exp = ((ad_cyc > x + 2) ? ad_cyc : x + 2) + 1;
         if (!done) chk("lastcolumn", lastcolumn, ack[0] >= 0 && cyc > ack[0]);
         chk("done", done, cyc == done_exp);
         if (done) begin
            chk("result", result, res_val);
            chk("col_strobes", cnt[0], 24);
            chk("top_strobes", cnt[1], 32);
            chk("bot_strobes", cnt[2], 32);
            alu_done = 1'b0;
            fin = 1;
         end
         rst_n = !(rst_rel > 0 && rel == rst_rel);
         nextcolumn = nx[0]; nextrowtop = nx[1]; nextrowbot = nx[2];
      end
      if (!fin) chk("run_timeout", 1'b0, 1'b1);
      tick();
      go = 1'b0;
      chk("idle_after_done", {busy, done}, 2'b00);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // all-zero bitmap, tightest acknowledge timing
      for (int i = 0; i < 64; i++) mem[i] = 24'd0;
      dly_lo = 2; dly_hi = 2;
      run_case(0, -1, -1, 13'h0ABC);
      chk("zero_col0", cap_col0, 64'd0);

      // single lit pixel at row 5, leftmost column; variable ALU delays
      mem[5] = 24'h800000;
      dly_lo = 2; dly_hi = 7;
      run_case(0, -1, -1, 13'h1234);
      chk("row5_col0", cap_col0, 64'h20);
      chk("row5_col1", cap_col1, 64'h0);
      chk("row5_top5", cap_top5, 24'h800000);

      // random picture with a stray go during FEED
      for (int i = 0; i < 64; i++) mem[i] = 24'($urandom);
      run_case(0, 100, -1, 13'h1F0F);

      // reset during LOAD, reset during FEED, then a clean run
      run_case(0, -1, 30, 13'h0001);
      run_case(0, -1, 150, 13'h0002);
      for (int i = 0; i < 64; i++) mem[i] = 24'($urandom);
      run_case(0, -1, -1, 13'h0777);

      // alu_done already high when the channels finish
      run_case(1, -1, -1, 13'h1555);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
